tp_trace_capture: RTL
=====================

// Module: tp_trace_capture
// PURPOSE
//  Parametrised on-chip probe/trace capture for debug test points (I2C state, counters, sensor words).
//  Samples NUM_CH probe channels into a circular buffer, with a pre-trigger window and a mask/value trigger.
//  Freezes the window on trigger, then streams it out oldest-first over a valid/ready port (UART/JTAG bridge).
//  Replaces ad-hoc probe port lists with one reusable capture engine.
// PARAMETERS
//  NUM_CH    4   number of probe channels
//  CH_W      16  bits per channel; probe word W = NUM_CH*CH_W
//  DEPTH     64  samples per capture; power of two >= 4; AW = $clog2(DEPTH)
//  PRE_TRIG  16  samples retained before the trigger sample; 0 <= PRE_TRIG < DEPTH
// PORTS
//  SYS_CLK     in   1   system clock
//  RESET_N     in   1   reset, asynchronous, active-low
//  PROBE       in   W   concatenated probe channels; ch0 = PROBE[CH_W-1:0]
//  SAMPLE_EN   in   1   qualifies PROBE as one sample this cycle
//  ARM         in   1   pulse: start capture (honoured in IDLE only)
//  ABORT       in   1   synchronous abort to IDLE; overrides all other inputs
//  TRIG_MASK   in   W   bits that take part in the compare
//  TRIG_VALUE  in   W   compare value
//  TRIG_EDGE   in   1   0 = level match, 1 = rising edge of match (previous sample not matching)
//  TRIG_FORCE  in   1   immediate trigger, gated by SAMPLE_EN
//  RD_READY    in   1   readout sink ready
//  RD_VALID    out  1   RD_DATA valid
//  RD_DATA     out  W   captured sample
//  RD_LAST     out  1   marks sample DEPTH-1 of the stream
//  ST_O        out  3   current FSM state, for status and probing
//  DONE        out  1   capture complete; high in DONE and READ
//  TRIG_IDX    out  AW  buffer address of the trigger sample
// BEHAVIOUR
//  Reset: all outputs 0. FSM in IDLE, pointers and counters 0. Buffer contents undefined.
//  Match: m = SAMPLE_EN & (((PROBE^TRIG_VALUE)&TRIG_MASK)==0).
//   Mask = 0 matches every sample. Edge mode: trig = m & ~m_prev.
//   m_prev updates only on SAMPLE_EN and clears on ARM.
//  FSM (encoding in package): IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4 READ=5.
//   IDLE: ARM -> PRE. Clears wr_ptr, pre_cnt, m_prev.
//   PRE: each SAMPLE_EN writes PROBE at wr_ptr, wr_ptr++ (mod DEPTH), pre_cnt++.
//     Triggers are ignored here. Once pre_cnt == PRE_TRIG, go to WAIT.
//     PRE_TRIG=0: PRE lasts one cycle, then WAIT.
//   WAIT: writes continue. On trig or TRIG_FORCE: write the sample, TRIG_IDX <= wr_ptr,
//     post_cnt <= DEPTH-PRE_TRIG-1, go to POST. If post_cnt would be 0, go straight to DONE.
//   POST: each SAMPLE_EN writes and decrements post_cnt. The write that takes post_cnt to 0 -> DONE.
//   DONE: writes stop. rd_ptr <= TRIG_IDX-PRE_TRIG (mod DEPTH), rd_cnt <= 0, go to READ.
//   READ: buffer read has 1-cycle registered latency. RD_VALID asserts 1 cycle after entry.
//     On RD_VALID&RD_READY: rd_ptr++, rd_cnt++, next word presented.
//     RD_DATA/RD_VALID/RD_LAST hold stable while RD_READY=0.
//     RD_LAST = (rd_cnt == DEPTH-1). Handshake on RD_LAST -> IDLE; RD_VALID drops next cycle.
//  Samples are stored in order: PRE_TRIG before the trigger, the trigger sample, DEPTH-PRE_TRIG-1 after.
//  Wrap: pointers are AW bits and wrap naturally. Waiting in WAIT overwrites the oldest samples.
//  ARM outside IDLE is ignored. SAMPLE_EN=0 stalls PRE/WAIT/POST without state change.
//  ABORT in any state: IDLE next cycle, RD_VALID/DONE cleared, TRIG_IDX kept.
//  Trigger and SAMPLE_EN in the same cycle as the PRE->WAIT transition: sample written, trigger ignored.
//  DONE stays high from DONE through the last read handshake.
// STRUCTURE
//  tp_pkg: state localparams (TP_IDLE..TP_READ), TP_ST_W=3, edge-mode constants.
//  Sub-module tp_ring_ram: simple dual-port RAM, DEPTH x W, one write port, one registered read port.
//   Inferable as M9K/M10K.
//  Top holds the FSM, trigger compare, pointers, counters and readout handshake.
// TESTING  (NUM_CH=2, CH_W=8, DEPTH=16, PRE_TRIG=4)
//  Ramp: PROBE=n on every cycle, ARM, mask 0x00FF value 0x0014, ready=1.
//   -> 16 words 0x10..0x1F, RD_LAST on 0x1F, TRIG_IDX holds 0x14's address.
//  Edge mode: PROBE holds 0x0014 for 3 samples, then 0x0000, then 0x0014.
//   -> trigger on the first 0x0014 only.
//  Early match during PRE (value 0x0002) ignored; TRIG_FORCE at sample 9.
//   -> stream 0x05..0x14, trigger word 0x09 at stream index 4.
//  Backpressure: RD_READY toggles 1/0 every cycle.
//   -> 16 unique words, data stable on stalls, no duplicates or drops.
//  ABORT asserted mid-POST and mid-READ -> ST_O=0 next cycle, RD_VALID=0. A re-ARM captures correctly.
//  RESET_N dropped asynchronously during READ -> all outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/tp_pkg.sv
// Shared definitions for the trace-capture engine: FSM state encoding and
// trigger edge-mode constants.
package tp_pkg;

    localparam int TP_ST_W = 3;

    typedef enum logic [TP_ST_W-1:0] {
        TP_IDLE = 3'd0,
        TP_PRE  = 3'd1,
        TP_WAIT = 3'd2,
        TP_POST = 3'd3,
        TP_DONE = 3'd4,
        TP_READ = 3'd5
    } tp_state_e;

    localparam logic TP_EDGE_LEVEL = 1'b0;
    localparam logic TP_EDGE_RISE  = 1'b1;

endpackage

// File: rtl/tp_ring_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered output so it maps onto block RAM.
module tp_ring_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tp_trace_capture.sv
// Probe capture engine: circular pre/post-trigger sampling into a ring buffer,
// then oldest-first readout over a valid/ready port.
module tp_trace_capture
    import tp_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 16,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16
) (
    input  logic                     SYS_CLK,
    input  logic                     RESET_N,
    input  logic [NUM_CH*CH_W-1:0]   PROBE,
    input  logic                     SAMPLE_EN,
    input  logic                     ARM,
    input  logic                     ABORT,
    input  logic [NUM_CH*CH_W-1:0]   TRIG_MASK,
    input  logic [NUM_CH*CH_W-1:0]   TRIG_VALUE,
    input  logic                     TRIG_EDGE,
    input  logic                     TRIG_FORCE,
    input  logic                     RD_READY,
    output logic                     RD_VALID,
    output logic [NUM_CH*CH_W-1:0]   RD_DATA,
    output logic                     RD_LAST,
    output logic [TP_ST_W-1:0]       ST_O,
    output logic                     DONE,
    output logic [$clog2(DEPTH)-1:0] TRIG_IDX
);

    localparam int W  = NUM_CH * CH_W;
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0] RD_END    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

    tp_state_e     st_q;
    logic [AW-1:0] wr_ptr_q, pre_cnt_q, post_cnt_q, trig_idx_q;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, rd_cnt_q;
    logic          m_prev_q, rd_valid_q, done_q;

    logic          match, trig, fire, wr_en, rd_en, rd_hs;
    logic [W-1:0]  ram_rdata;

    assign match = SAMPLE_EN && (((PROBE ^ TRIG_VALUE) & TRIG_MASK) == '0);
    assign trig  = (TRIG_EDGE == TP_EDGE_RISE) ? (match && !m_prev_q) : match;
    assign fire  = trig || (TRIG_FORCE && SAMPLE_EN);
    assign rd_hs = rd_valid_q && RD_READY;
    assign rd_en = (st_q == TP_DONE) || (st_q == TP_READ);

    always_comb begin
        wr_en = 1'b0;
        if (!ABORT) begin
            case (st_q)
                TP_PRE:           wr_en = SAMPLE_EN && (PRE_TRIG != 0);
                TP_WAIT, TP_POST: wr_en = SAMPLE_EN;
                default:          wr_en = 1'b0;
            endcase
        end
    end

    // The RAM is addressed with the next read pointer so a handshake presents
    // the following word on the very next cycle without a bubble.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (st_q == TP_DONE) begin
            rd_ptr_d = trig_idx_q - PRE_OFS;
        end else if (st_q == TP_READ && rd_hs) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q       <= TP_IDLE;
            wr_ptr_q   <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            trig_idx_q <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            m_prev_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (ABORT) begin
            st_q       <= TP_IDLE;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (SAMPLE_EN) begin
                m_prev_q <= match;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ONE;
            end
            rd_ptr_q <= rd_ptr_d;

            case (st_q)
                TP_IDLE: begin
                    if (ARM) begin
                        st_q      <= TP_PRE;
                        wr_ptr_q  <= '0;
                        pre_cnt_q <= '0;
                        m_prev_q  <= 1'b0;
                    end
                end
                TP_PRE: begin
                    if (PRE_TRIG == 0) begin
                        st_q <= TP_WAIT;
                    end else if (SAMPLE_EN) begin
                        pre_cnt_q <= pre_cnt_q + ONE;
                        if (pre_cnt_q == PRE_LAST) begin
                            st_q <= TP_WAIT;
                        end
                    end
                end
                TP_WAIT: begin
                    if (fire) begin
                        trig_idx_q <= wr_ptr_q;
                        post_cnt_q <= POST_INIT;
                        if (POST_INIT == '0) begin
                            st_q   <= TP_DONE;
                            done_q <= 1'b1;
                        end else begin
                            st_q <= TP_POST;
                        end
                    end
                end
                TP_POST: begin
                    if (SAMPLE_EN) begin
                        post_cnt_q <= post_cnt_q - ONE;
                        if (post_cnt_q == ONE) begin
                            st_q   <= TP_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                TP_DONE: begin
                    rd_cnt_q <= '0;
                    st_q     <= TP_READ;
                end
                TP_READ: begin
                    if (rd_hs) begin
                        rd_cnt_q <= rd_cnt_q + ONE;
                    end
                    if (rd_hs && rd_cnt_q == RD_END) begin
                        st_q       <= TP_IDLE;
                        rd_valid_q <= 1'b0;
                        done_q     <= 1'b0;
                    end else begin
                        rd_valid_q <= 1'b1;
                    end
                end
                default: st_q <= TP_IDLE;
            endcase
        end
    end

    tp_ring_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (SYS_CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (PROBE),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    // Data is gated by valid so the port reads zero whenever nothing is offered.
    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_valid_q ? ram_rdata : '0;
    assign RD_LAST  = rd_valid_q && (rd_cnt_q == RD_END);
    assign ST_O     = st_q;
    assign DONE     = done_q;
    assign TRIG_IDX = trig_idx_q;

endmodule
